// File: rtl/state_trace_pkg.sv
// Shared widths, entry field layout and packing helper for the state trace buffer.
package state_trace_pkg;

  localparam int ST_W    = 3;
  localparam int CNT_W   = 8;
  localparam int ENTRY_W = 2 * ST_W + CNT_W;

  // Entry layout, old state in the MSBs: {old_state, new_state, dwell}
  localparam int DWELL_LSB = 0;
  localparam int NEW_LSB   = CNT_W;
  localparam int OLD_LSB   = CNT_W + ST_W;

  localparam logic [CNT_W-1:0] DWELL_MAX = '1;

  function automatic logic [ENTRY_W-1:0] packEntry(input logic [ST_W-1:0]  oldSt,
                                                   input logic [ST_W-1:0]  newSt,
                                                   input logic [CNT_W-1:0] dwell);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[OLD_LSB +: ST_W]    = oldSt;
    e[NEW_LSB +: ST_W]    = newSt;
    e[DWELL_LSB +: CNT_W] = dwell;
    return e;
  endfunction

endpackage

// File: rtl/state_trace_buffer_if.sv
// Read-side bundle of the trace buffer: show-ahead head entry, valid/ready and fill level.
interface state_trace_buffer_if #(parameter int DEPTH = 8);
  import state_trace_pkg::*;

  localparam int COUNT_W = $clog2(DEPTH) + 1;

  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;
  logic [COUNT_W-1:0] count;

  modport master (output rd_valid, output rd_data, output count, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input count, output rd_ready);

endinterface

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted when a pop frees a slot that same edge.
module trace_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPop;
  logic             w_doPush;

  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_FULL);
  assign count    = r_count;
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);
  assign head_data = empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      if (w_doPush && !w_doPop)
        r_count <= r_count + CNT_ONE;
      else if (!w_doPush && w_doPop)
        r_count <= r_count - CNT_ONE;
    end
  end

  // Storage needs no reset: head_data is masked while empty.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= push_data;
  end

endmodule

// File: rtl/state_trace_buffer.sv
// Logs every change of an observed state code as {old, new, dwell} into a FIFO, with stall and overflow flags.
module state_trace_buffer
  import state_trace_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int STALL_LIMIT = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [ST_W-1:0]        st_in,
  input  logic                   clr_flags,
  state_trace_buffer_if.master   rd,
  output logic                   overflow,
  output logic                   stall
);

  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);

  logic [ST_W-1:0]         r_prevState;
  logic [CNT_W-1:0]        r_dwell;
  logic                    r_primed;
  logic                    r_overflow;
  logic                    r_stall;
  logic [ST_W-1:0]         w_prevNext;
  logic [CNT_W-1:0]        w_dwellNext;
  logic                    w_primedNext;
  logic                    w_change;
  logic                    w_pop;
  logic                    w_overflowEvent;
  logic                    w_fifoFull;
  logic                    w_fifoEmpty;
  logic [ENTRY_W-1:0]      w_headData;
  logic [$clog2(DEPTH):0]  w_count;

  assign w_change        = en && r_primed && (st_in != r_prevState);
  assign w_pop           = rd.rd_ready && !w_fifoEmpty;
  assign w_overflowEvent = w_change && w_fifoFull && !w_pop;

  // Next-state view of the detector; everything freezes while en is low.
  always_comb begin
    w_prevNext   = r_prevState;
    w_dwellNext  = r_dwell;
    w_primedNext = r_primed;
    if (en) begin
      if (!r_primed || w_change) begin
        w_prevNext   = st_in;
        w_dwellNext  = DWELL_ONE;
        w_primedNext = 1'b1;
      end else if (r_dwell != DWELL_MAX) begin
        w_dwellNext  = r_dwell + DWELL_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prevState <= '0;
      r_dwell     <= '0;
      r_primed    <= 1'b0;
      r_stall     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_prevState <= w_prevNext;
      r_dwell     <= w_dwellNext;
      r_primed    <= w_primedNext;
      r_stall     <= w_primedNext && (w_dwellNext >= STALL_TH);
      // A dropped entry in the same cycle as a clear keeps the flag set.
      if (w_overflowEvent)
        r_overflow <= 1'b1;
      else if (clr_flags)
        r_overflow <= 1'b0;
    end
  end

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_change),
    .push_data (packEntry(r_prevState, st_in, r_dwell)),
    .pop       (rd.rd_ready),
    .head_data (w_headData),
    .count     (w_count),
    .full      (w_fifoFull),
    .empty     (w_fifoEmpty)
  );

  assign rd.rd_valid = !w_fifoEmpty;
  assign rd.rd_data  = w_headData;
  assign rd.count    = w_count;
  assign overflow    = r_overflow;
  assign stall       = r_stall;

endmodule

// File: tb/tb_state_trace_buffer.sv
// Scoreboard bench for state_trace_buffer: a behavioural model queues expected entries as stimulus is applied.
module tb_state_trace_buffer;
  import state_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int LIMIT = 100;

  logic            clk;
  logic            reset;
  logic            en;
  logic [ST_W-1:0] stIn;
  logic            clrFlags;
  logic            overflow;
  logic            stall;

  state_trace_buffer_if #(.DEPTH(DEPTH)) rdIf ();

  state_trace_buffer #(.DEPTH(DEPTH), .STALL_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .st_in     (stIn),
    .clr_flags (clrFlags),
    .rd        (rdIf.master),
    .overflow  (overflow),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun = 0;
  int failed   = 0;

  logic [ENTRY_W-1:0] sb[$];
  logic [ST_W-1:0]    mPrev;
  int                 mDwell;
  bit                 mPrimed;
  int                 mCount;
  bit                 mOvf;
  bit                 mStall;

  task automatic modelClear();
    sb.delete();
    mPrev = '0; mDwell = 0; mPrimed = 0; mCount = 0; mOvf = 0; mStall = 0;
  endtask

  task automatic resetDut();
    en = 1'b0; clrFlags = 1'b0; rdIf.rd_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelClear();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, pop/compare the scoreboard on an accepted read, and advance the model.
  task automatic applyStimulus(input bit e, input logic [ST_W-1:0] s, input bit rdy, input bit clr);
    bit popping, change, ovfEv;
    int nextCount;
    logic [ENTRY_W-1:0] exp;
    en = e; stIn = s; rdIf.rd_ready = rdy; clrFlags = clr;
    popping = rdy && (mCount > 0);
    if (popping) begin
      exp = sb.pop_front();
      testsRun++;
      if (rdIf.rd_data !== exp) begin
        failed++;
        $display("[TB] FAIL scoreboard_entry: got %h expected %h", rdIf.rd_data, exp);
      end
    end
    change = e && mPrimed && (s != mPrev);
    ovfEv = 0;
    nextCount = mCount - (popping ? 1 : 0);
    if (change) begin
      if (mCount < DEPTH || popping) begin
        sb.push_back({mPrev, s, CNT_W'(mDwell)});
        nextCount++;
      end else begin
        ovfEv = 1;
      end
    end
    if (e) begin
      if (!mPrimed || change) begin
        mPrev = s; mDwell = 1; mPrimed = 1;
      end else if (mDwell < 255) begin
        mDwell++;
      end
    end
    if (ovfEv) mOvf = 1;
    else if (clr) mOvf = 0;
    mStall = mPrimed && (mDwell >= LIMIT);
    mCount = nextCount;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && mCount > 0; i++) applyStimulus(0, stIn, 1, 0);
    testsRun++;
    if (rdIf.count !== '0) begin
      failed++;
      $display("[TB] FAIL drain_count: got %0d expected 0", rdIf.count);
    end
  endtask

  task automatic test_reset();
    resetDut();
    testsRun++;
    if ({rdIf.rd_valid, rdIf.count, overflow, stall} !== '0 || rdIf.rd_data !== '0) begin
      failed++;
      $display("[TB] FAIL reset_state: got valid=%b count=%0d ovf=%b stall=%b data=%h expected all 0",
               rdIf.rd_valid, rdIf.count, overflow, stall, rdIf.rd_data);
    end
  endtask

  task automatic test_basic_log();
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(1, 3'd1, 0, 0);
    applyStimulus(1, 3'd2, 0, 0);
    testsRun++;
    if (rdIf.rd_valid !== 1'b1 || rdIf.count !== 4'd1 || rdIf.rd_data !== {3'd1, 3'd2, 8'd4}) begin
      failed++;
      $display("[TB] FAIL basic_entry: got valid=%b count=%0d data=%h expected 1 1 %h",
               rdIf.rd_valid, rdIf.count, rdIf.rd_data, {3'd1, 3'd2, 8'd4});
    end
    applyStimulus(0, 3'd2, 1, 0);
    testsRun++;
    if (rdIf.rd_valid !== 1'b0 || rdIf.count !== 4'd0 || rdIf.rd_data !== '0) begin
      failed++;
      $display("[TB] FAIL basic_pop: got valid=%b count=%0d data=%h expected 0 0 0",
               rdIf.rd_valid, rdIf.count, rdIf.rd_data);
    end
  endtask

  task automatic test_priming_reset();
    resetDut();
    applyStimulus(1, 3'd5, 0, 0);
    testsRun++;
    if (rdIf.rd_valid !== 1'b0 || rdIf.count !== 4'd0) begin
      failed++;
      $display("[TB] FAIL prime_no_entry: got valid=%b count=%0d expected 0 0", rdIf.rd_valid, rdIf.count);
    end
    applyStimulus(1, 3'd6, 0, 0);
    applyStimulus(1, 3'd7, 0, 0);
    applyStimulus(1, 3'd1, 0, 0);
    testsRun++;
    if (rdIf.count !== 4'd3) begin
      failed++;
      $display("[TB] FAIL prime_three: got count=%0d expected 3", rdIf.count);
    end
    resetDut();
    testsRun++;
    if (rdIf.count !== 4'd0 || overflow !== 1'b0 || rdIf.rd_valid !== 1'b0) begin
      failed++;
      $display("[TB] FAIL midrun_reset: got count=%0d ovf=%b valid=%b expected 0 0 0",
               rdIf.count, overflow, rdIf.rd_valid);
    end
    applyStimulus(1, 3'd3, 0, 0);
    applyStimulus(1, 3'd3, 0, 0);
    applyStimulus(1, 3'd4, 0, 0);
    testsRun++;
    if (rdIf.count !== 4'd1 || rdIf.rd_data !== {3'd3, 3'd4, 8'd2}) begin
      failed++;
      $display("[TB] FAIL reprime_entry: got count=%0d data=%h expected 1 %h",
               rdIf.count, rdIf.rd_data, {3'd3, 3'd4, 8'd2});
    end
    drain();
  endtask

  task automatic test_overflow();
    resetDut();
    applyStimulus(1, 3'd0, 0, 0);
    for (int i = 1; i <= 9; i++) applyStimulus(1, 3'(i % 8), 0, 0);
    testsRun++;
    if (rdIf.count !== 4'd8 || overflow !== 1'b1 || sb.size() != 8) begin
      failed++;
      $display("[TB] FAIL overflow_drop: got count=%0d ovf=%b expected 8 1", rdIf.count, overflow);
    end
    drain();
    resetDut();
    applyStimulus(1, 3'd0, 0, 0);
    for (int i = 1; i <= 8; i++) applyStimulus(1, 3'(i % 8), 0, 0);
    applyStimulus(1, 3'd1, 1, 0);
    testsRun++;
    if (rdIf.count !== 4'd8 || overflow !== 1'b0) begin
      failed++;
      $display("[TB] FAIL full_push_pop: got count=%0d ovf=%b expected 8 0", rdIf.count, overflow);
    end
    applyStimulus(1, 3'd2, 0, 0);
    testsRun++;
    if (overflow !== 1'b1) begin
      failed++;
      $display("[TB] FAIL overflow_set: got %b expected 1", overflow);
    end
    applyStimulus(1, 3'd2, 0, 1);
    testsRun++;
    if (overflow !== 1'b0) begin
      failed++;
      $display("[TB] FAIL clr_flags: got %b expected 0", overflow);
    end
    applyStimulus(1, 3'd3, 0, 1);
    testsRun++;
    if (overflow !== 1'b1) begin
      failed++;
      $display("[TB] FAIL set_wins_clr: got %b expected 1", overflow);
    end
    drain();
  endtask

  task automatic test_en_gating();
    logic [ST_W-1:0] gated [5] = '{3'd2, 3'd6, 3'd6, 3'd2, 3'd2};
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1, 3'd2, 0, 0);
    foreach (gated[i]) applyStimulus(0, gated[i], 0, 0);
    testsRun++;
    if (rdIf.count !== 4'd0) begin
      failed++;
      $display("[TB] FAIL en_low_no_log: got count=%0d expected 0", rdIf.count);
    end
    applyStimulus(1, 3'd2, 0, 0);
    applyStimulus(1, 3'd7, 0, 0);
    testsRun++;
    if (rdIf.count !== 4'd1 || rdIf.rd_data !== {3'd2, 3'd7, 8'd4}) begin
      failed++;
      $display("[TB] FAIL en_gated_entry: got count=%0d data=%h expected 1 %h",
               rdIf.count, rdIf.rd_data, {3'd2, 3'd7, 8'd4});
    end
    drain();
  endtask

  task automatic test_stall();
    resetDut();
    for (int i = 0; i < LIMIT - 1; i++) applyStimulus(1, 3'd3, 0, 0);
    testsRun++;
    if (stall !== 1'b0) begin
      failed++;
      $display("[TB] FAIL stall_early: got %b expected 0", stall);
    end
    applyStimulus(1, 3'd3, 0, 0);
    testsRun++;
    if (stall !== 1'b1) begin
      failed++;
      $display("[TB] FAIL stall_at_limit: got %b expected 1", stall);
    end
    for (int i = LIMIT; i < 300; i++) applyStimulus(1, 3'd3, 0, 0);
    applyStimulus(1, 3'd0, 0, 0);
    testsRun++;
    if (rdIf.rd_data !== {3'd3, 3'd0, 8'd255} || stall !== 1'b0) begin
      failed++;
      $display("[TB] FAIL saturate_entry: got data=%h stall=%b expected %h 0",
               rdIf.rd_data, stall, {3'd3, 3'd0, 8'd255});
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [ST_W-1:0] cur;
    int gap;
    resetDut();
    cur = 3'd0;
    applyStimulus(1, cur, 0, 0);
    for (int n = 0; n < 80; n++) begin
      gap = $urandom_range(1, 3);
      for (int g = 1; g < gap; g++) applyStimulus(1, cur, bit'($urandom_range(0, 1)), 0);
      cur = 3'((int'(cur) + $urandom_range(1, 7)) % 8);
      applyStimulus(1, cur, bit'($urandom_range(0, 1)), 0);
      testsRun++;
      if (rdIf.count !== 4'(mCount) || overflow !== mOvf || stall !== mStall || int'(rdIf.count) > DEPTH) begin
        failed++;
        $display("[TB] FAIL stress_state: got count=%0d ovf=%b stall=%b expected %0d %b %b",
                 rdIf.count, overflow, stall, mCount, mOvf, mStall);
      end
    end
    drain();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; stIn = '0; clrFlags = 1'b0; rdIf.rd_ready = 1'b0;
    modelClear();
    test_reset();
    test_basic_log();
    test_priming_reset();
    test_overflow();
    test_en_gating();
    test_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, failed);
    $finish;
  end

endmodule

// File: doc/state_trace_buffer.md
Name: state_trace_buffer

Overview:
- Downstream consumer of the 3-bit Moore state-machine output code.
- Watches the state code every enabled clock and detects each state change.
- On each change, logs one entry {old_state, new_state, dwell_cycles} into a small FIFO that a host drains with a valid/ready handshake.
- Also flags a stuck state (stall) and lost entries (overflow); gives the team cycle-accurate traces of the state machine without a waveform dump.

Parameters:
- ST_W, 3: width of the observed state code.
- CNT_W, 8: dwell counter width; the counter saturates at 2^CNT_W-1.
- DEPTH, 8: FIFO entries; must be a power of two, minimum 2.
- STALL_LIMIT, 100: dwell count at which stall asserts; must be ≤ 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  sample enable; when low, detection and dwell counting freeze.
- st_in  in  ST_W  state code from the upstream Moore machine output.
- clr_flags  in  1  synchronous clear of the sticky overflow flag.
- rd_valid  out  1  FIFO non-empty; rd_data is valid.
- rd_ready  in  1  consumer accepts the head entry when rd_valid is high.
- rd_data  out  2*ST_W+CNT_W  entry bits: {old_state[ST_W-1:0], new_state[ST_W-1:0], dwell[CNT_W-1:0]}, old_state in the MSBs.
- count  out  $clog2(DEPTH)+1  number of entries held.
- overflow  out  1  sticky; set when a change is dropped because the FIFO is full.
- stall  out  1  current state has dwelt ≥ STALL_LIMIT cycles.

Behaviour:
- Reset values (asynchronous): rd_valid=0, count=0, overflow=0, stall=0, rd_data=0, FIFO pointers=0, prev_state=0, dwell=0, primed=0.
- Priming: the first enabled cycle after reset loads prev_state<=st_in and dwell<=1, sets primed=1, and pushes nothing.
- Change, defined as en && primed && st_in!=prev_state, at edge k:
  - push {prev_state, st_in, dwell}, using dwell's value before edge k;
  - then prev_state<=st_in and dwell<=1.
- No change with en high: dwell<=dwell+1, saturating at all-ones.
- en low: every register holds, including the FIFO write side. Reads still proceed.
- Dwell semantics: dwell equals the number of enabled samples on which old_state was observed.
- Push/read latency: an entry pushed at edge k gives rd_valid=1 and the entry on rd_data after edge k. rd_data is show-ahead, driven from the head entry, and is 0 when empty.
- Pop: rd_valid && rd_ready at an edge removes the head entry. rd_ready while empty is ignored.
- Simultaneous push and pop:
  - when not full: count is unchanged and both proceed;
  - when full: the pop frees a slot, so the push is accepted and overflow is not set.
- Full with no pop: the push is dropped, overflow<=1, and prev_state/dwell still update as for a normal change.
- clr_flags clears overflow at the edge. If an overflow event occurs in the same cycle, set wins.
- stall is registered: it is 1 when primed && dwell≥STALL_LIMIT, and clears on the edge that logs a change.
- Reset mid-operation: the FIFO contents are discarded, and the next enabled sample re-primes without logging a change across the reset.
- Width rules:
  - count ranges 0..DEPTH;
  - pointers are $clog2(DEPTH) bits and wrap modulo DEPTH;
  - full is count==DEPTH.

Decomposition:
- Shared package state_trace_pkg holds:
  - ST_W, CNT_W and the entry width constant ENTRY_W=2*ST_W+CNT_W;
  - field offset constants for old, new and dwell;
  - the dwell saturation max constant.
- Sub-module trace_fifo: a synchronous show-ahead FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, reset, push, push_data, pop, head_data, count, full, empty.
  - Behaviour: it implements the push-when-full-with-pop rule internally.
- The top level contains only the change detector, dwell counter, stall logic and flags.

Test Plan:
1. Basic log: release reset, en=1, st_in=1 for 4 cycles, then 2 → one entry {1,2,4}, rd_valid=1 on the cycle after the change edge, count=1. Pop with rd_ready → rd_valid=0, count=0, rd_data=0.
2. Priming and reset: st_in=5 at the first enabled sample → no entry. Assert reset mid-run with 3 entries held → count=0, overflow=0. Then hold 3 for 2 cycles and go to 4 → only {3,4,2} is logged.
3. Overflow: 9 changes with rd_ready=0 and DEPTH=8 → count=8, overflow=1, and the 9th entry is absent. Repeat with a pop on the 9th change edge → overflow stays 0 and count=8. clr_flags with no event → overflow=0.
4. en gating: st_in=2 for 3 enabled cycles, en=0 for 5 cycles while st_in toggles 2→6→2, then en=1 for one cycle, then st_in=7 → single entry {2,7,4}; no entries during en=0.
5. Stall and saturation: STALL_LIMIT=100, hold st_in=3 for 300 cycles → stall rises after dwell reaches 100 and dwell saturates at 255. Change to 0 → entry {3,0,255}, stall=0 after that edge.
6. Handshake stress: random rd_ready with a change every 1–3 cycles → the scoreboard matches entry order and values exactly, count never exceeds 8, and overflow=1 only when a push coincides with full and no pop.
